// File: rtl/click_region_pkg.sv
// Shared types and constants for the multi-region click detector.
package click_region_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_MISS
  } state_e;

  localparam int MODE_PRESS = 0;
  localparam int MODE_CLICK = 1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/click_region_if.sv
// Mouse/geometry inputs and click outputs between mouse controller, game logic and the detector.
interface click_region_if #(
  parameter int NUM_REGIONS = 4,
  parameter int POS_W       = 12,
  parameter int GEOM_W      = 11
);
  localparam int ID_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

  logic [POS_W-1:0]              mouse_xpos;
  logic [POS_W-1:0]              mouse_ypos;
  logic                          mouse_left;
  logic [NUM_REGIONS*GEOM_W-1:0] hstart;
  logic [NUM_REGIONS*GEOM_W-1:0] vstart;
  logic [NUM_REGIONS*GEOM_W-1:0] hlength;
  logic [NUM_REGIONS*GEOM_W-1:0] vlength;
  logic [NUM_REGIONS-1:0]        region_en;
  logic                          clear;
  logic [NUM_REGIONS-1:0]        hover;
  logic                          click_pulse;
  logic [ID_W-1:0]               click_id;
  logic [NUM_REGIONS-1:0]        region_clicked;

  modport master (
    output mouse_xpos, mouse_ypos, mouse_left, hstart, vstart, hlength, vlength,
           region_en, clear,
    input  hover, click_pulse, click_id, region_clicked
  );

  modport slave (
    input  mouse_xpos, mouse_ypos, mouse_left, hstart, vstart, hlength, vlength,
           region_en, clear,
    output hover, click_pulse, click_id, region_clicked
  );

endinterface

// File: rtl/click_region_ctl_rect_hit.sv
// Single-rectangle inclusive hit test; arithmetic is widened so origin+length never wraps.
module rect_hit
  import click_region_pkg::*;
#(
  parameter int POS_W  = 12,
  parameter int GEOM_W = 11
) (
  input  logic [POS_W-1:0]  x_i,
  input  logic [POS_W-1:0]  y_i,
  input  logic [GEOM_W-1:0] hstart_i,
  input  logic [GEOM_W-1:0] vstart_i,
  input  logic [GEOM_W-1:0] hlength_i,
  input  logic [GEOM_W-1:0] vlength_i,
  input  logic              en_i,
  output logic              hit_o
);
  localparam int W = max_int(POS_W, GEOM_W + 1);

  logic [W-1:0] x_w, y_w, xs_w, ys_w, xe_w, ye_w;

  assign x_w  = W'(x_i);
  assign y_w  = W'(y_i);
  assign xs_w = W'(hstart_i);
  assign ys_w = W'(vstart_i);
  assign xe_w = W'(hstart_i) + W'(hlength_i);
  assign ye_w = W'(vstart_i) + W'(vlength_i);

  assign hit_o = en_i && (x_w >= xs_w) && (x_w <= xe_w) && (y_w >= ys_w) && (y_w <= ye_w);

endmodule

// File: rtl/click_region_ctl.sv
// Multi-region click detector: two-stage sample/hit pipeline, priority encode, press or click FSM, sticky latches.
module click_region_ctl
  import click_region_pkg::*;
#(
  parameter int NUM_REGIONS = 4,
  parameter int POS_W       = 12,
  parameter int GEOM_W      = 11,
  parameter int MODE        = MODE_PRESS
) (
  input  logic         pclk,
  input  logic         rst,
  click_region_if.slave bus
);
  localparam int ID_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

  logic [POS_W-1:0]       xpos_q, ypos_q;
  logic                   left_q, first_q, press_q, release_q;
  logic [NUM_REGIONS-1:0] hit_d, hit_q;
  logic                   press2_q, release2_q;
  logic [ID_W-1:0]        hit_id;
  logic                   any_hit, event_d;
  state_e                 state_q;
  logic [ID_W-1:0]        arm_id_q, id_q;
  logic                   pulse_q;
  logic [NUM_REGIONS-1:0] clicked_q;

  for (genvar i = 0; i < NUM_REGIONS; i++) begin : g_region
    rect_hit #(.POS_W(POS_W), .GEOM_W(GEOM_W)) u_hit (
      .x_i      (xpos_q),
      .y_i      (ypos_q),
      .hstart_i (bus.hstart[i*GEOM_W +: GEOM_W]),
      .vstart_i (bus.vstart[i*GEOM_W +: GEOM_W]),
      .hlength_i(bus.hlength[i*GEOM_W +: GEOM_W]),
      .vlength_i(bus.vlength[i*GEOM_W +: GEOM_W]),
      .en_i     (bus.region_en[i]),
      .hit_o    (hit_d[i])
    );
  end

  // first_q keeps a button already held across reset from looking like a fresh press.
  always_ff @(posedge pclk) begin
    // NOTE: every register here uses <= so all stages read the values from before this edge.
    if (rst) begin
      xpos_q     <= '0;
      ypos_q     <= '0;
      left_q     <= 1'b0;
      first_q    <= 1'b1;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      hit_q      <= '0;
      press2_q   <= 1'b0;
      release2_q <= 1'b0;
    end else begin
      xpos_q     <= bus.mouse_xpos;
      ypos_q     <= bus.mouse_ypos;
      left_q     <= bus.mouse_left;
      first_q    <= 1'b0;
      press_q    <= bus.mouse_left & ~left_q & ~first_q;
      release_q  <= ~bus.mouse_left & left_q;
      hit_q      <= hit_d;
      press2_q   <= press_q;
      release2_q <= release_q;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through this block leaves a value held (no latch).
    hit_id  = '0;
    any_hit = |hit_q;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (hit_q[i]) hit_id = ID_W'(i);
    end
    if (MODE == MODE_PRESS) event_d = press2_q & any_hit;
    else event_d = (state_q == ST_ARMED) & release2_q & any_hit & (hit_id == arm_id_q);
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      arm_id_q  <= '0;
      pulse_q   <= 1'b0;
      id_q      <= '0;
      clicked_q <= '0;
    end else begin
      if (MODE == MODE_CLICK) begin
        case (state_q)
          ST_IDLE: if (press2_q) begin
            if (any_hit) begin
              state_q  <= ST_ARMED;
              arm_id_q <= hit_id;
            end else begin
              state_q <= ST_MISS;
            end
          end
          ST_ARMED: if (release2_q) state_q <= ST_IDLE;
          ST_MISS:  if (release2_q) state_q <= ST_IDLE;
          default:  state_q <= ST_IDLE;
        endcase
      end
      pulse_q <= event_d;
      id_q    <= event_d ? hit_id : '0;
      if (bus.clear) clicked_q <= '0;
      else if (event_d) clicked_q[hit_id] <= 1'b1;
    end
  end

  assign bus.hover          = hit_q;
  assign bus.click_pulse    = pulse_q;
  assign bus.click_id       = id_q;
  assign bus.region_clicked = clicked_q;

endmodule

// File: tb/tb_click_region_ctl.sv
// Directed bench: one press-mode and one click-mode detector driven with identical mouse/geometry stimulus.
module tb_click_region_ctl;
  logic        pclk = 1'b0;
  logic        rst;
  logic [11:0] mx, my;
  logic        ml, clr;
  logic [3:0]  en;
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 pclk = ~pclk;

  click_region_if #(.NUM_REGIONS(4), .POS_W(12), .GEOM_W(11)) if0 ();
  click_region_if #(.NUM_REGIONS(4), .POS_W(12), .GEOM_W(11)) if1 ();

  // r0=(100,100,50,50) r1=(120,120,40,40) r2=(130,130,10,10) r3=(2047,0,2047,2047)
  localparam logic [43:0] HS = {11'd2047, 11'd130, 11'd120, 11'd100};
  localparam logic [43:0] VS = {11'd0,    11'd130, 11'd120, 11'd100};
  localparam logic [43:0] HL = {11'd2047, 11'd10,  11'd40,  11'd50};
  localparam logic [43:0] VL = {11'd2047, 11'd10,  11'd40,  11'd50};

  assign if0.mouse_xpos = mx;  assign if1.mouse_xpos = mx;
  assign if0.mouse_ypos = my;  assign if1.mouse_ypos = my;
  assign if0.mouse_left = ml;  assign if1.mouse_left = ml;
  assign if0.hstart     = HS;  assign if1.hstart     = HS;
  assign if0.vstart     = VS;  assign if1.vstart     = VS;
  assign if0.hlength    = HL;  assign if1.hlength    = HL;
  assign if0.vlength    = VL;  assign if1.vlength    = VL;
  assign if0.region_en  = en;  assign if1.region_en  = en;
  assign if0.clear      = clr; assign if1.clear      = clr;

  click_region_ctl #(.NUM_REGIONS(4), .POS_W(12), .GEOM_W(11), .MODE(0)) u_dut0 (
    .pclk(pclk), .rst(rst), .bus(if0.slave));
  click_region_ctl #(.NUM_REGIONS(4), .POS_W(12), .GEOM_W(11), .MODE(1)) u_dut1 (
    .pclk(pclk), .rst(rst), .bus(if1.slave));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic at(input int x, input int y);
    mx = 12'(x);
    my = 12'(y);
  endtask

  initial begin
    rst = 1'b1; ml = 1'b0; clr = 1'b0; en = 4'b1111; at(0, 0);
    step(3);
    check("rst_pulse0", 32'(if0.click_pulse), 0);
    check("rst_pulse1", 32'(if1.click_pulse), 0);
    check("rst_hover", 32'(if0.hover), 0);
    check("rst_clicked", 32'({if1.region_clicked, if0.region_clicked}), 0);
    rst = 1'b0;
    step(1);

    // Press at the far corner of r0 (also inside r1): id 0 at k+2, no repeat while held.
    at(150, 150); step(2);
    check("hover_150", 32'(if0.hover), 32'b0011);
    ml = 1'b1; step(2);
    check("lat_k1", 32'(if0.click_pulse), 0);
    step(1);
    check("press_pulse", 32'(if0.click_pulse), 1);
    check("press_id", 32'(if0.click_id), 0);
    check("press_sticky", 32'(if0.region_clicked), 32'b0001);
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("held_norepeat", 32'(if0.click_pulse), 0);
    end
    ml = 1'b0; step(3);
    check("m1_release_pulse", 32'(if1.click_pulse), 1);
    check("m1_release_id", 32'(if1.click_id), 0);
    check("m0_no_release_evt", 32'(if0.click_pulse), 0);
    check("m1_sticky", 32'(if1.region_clicked), 32'b0001);

    // Outside r0 by one pixel, only r0 enabled.
    en = 4'b0001; at(151, 120); step(2);
    check("hover_151", 32'(if0.hover), 0);
    ml = 1'b1; step(3);
    check("miss_pulse0", 32'(if0.click_pulse), 0);
    ml = 1'b0; step(3);
    check("miss_pulse1", 32'(if1.click_pulse), 0);

    // Lower boundary is inclusive.
    at(100, 100); step(2);
    check("hover_100", 32'(if0.hover), 32'b0001);
    ml = 1'b1; step(3);
    check("bound_pulse", 32'(if0.click_pulse), 1);
    ml = 1'b0; step(3);

    // Overlap r1/r2 with r0 disabled: lowest enabled index wins.
    en = 4'b1110; at(135, 135); step(2);
    check("hover_ovl", 32'(if0.hover), 32'b0110);
    ml = 1'b1; step(3);
    check("ovl_pulse", 32'(if0.click_pulse), 1);
    check("ovl_id", 32'(if0.click_id), 1);
    check("ovl_sticky", 32'(if0.region_clicked), 32'b0011);
    ml = 1'b0; step(3);
    check("ovl_m1_id", 32'(if1.click_id), 1);
    check("ovl_m1_sticky", 32'(if1.region_clicked), 32'b0011);

    // Click mode: release outside gives nothing; drag out and back still clicks.
    en = 4'b1111; at(110, 110); step(2);
    ml = 1'b1; step(3);
    at(300, 300); step(1);
    ml = 1'b0; step(3);
    check("m1_drag_off", 32'(if1.click_pulse), 0);
    step(1);
    check("m1_drag_off_late", 32'(if1.click_pulse), 0);
    at(110, 110); ml = 1'b1; step(3);
    at(300, 300); step(2);
    at(110, 110); step(2);
    ml = 1'b0; step(3);
    check("m1_drag_back", 32'(if1.click_pulse), 1);
    step(1);
    check("m1_single_evt", 32'(if1.click_pulse), 0);

    // Clear alone, then clear colliding with an event.
    clr = 1'b1; step(1); clr = 1'b0;
    check("clear_m0", 32'(if0.region_clicked), 0);
    check("clear_m1", 32'(if1.region_clicked), 0);
    ml = 1'b1; step(2);
    clr = 1'b1; step(1); clr = 1'b0;
    check("clr_evt_pulse", 32'(if0.click_pulse), 1);
    check("clr_evt_sticky", 32'(if0.region_clicked), 0);
    step(1);
    check("clr_evt_after", 32'(if0.region_clicked), 0);
    ml = 1'b0; step(3);
    check("m1_after_clr", 32'(if1.region_clicked), 32'b0001);

    // Armed region disabled before release: no event.
    ml = 1'b1; step(3);
    en = 4'b1110;
    ml = 1'b0; step(3);
    check("armed_disabled", 32'(if1.click_pulse), 0);

    // Disabled r0 neither hovers nor clicks.
    step(2);
    check("dis_hover", 32'(if0.hover), 0);
    ml = 1'b1; step(3);
    check("dis_pulse", 32'(if0.click_pulse), 0);
    ml = 1'b0; step(3);

    // Button held across reset: no press after reset, no release event either.
    en = 4'b1111; rst = 1'b1; ml = 1'b1; step(3);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("rst_held_m0", 32'(if0.click_pulse), 0);
    end
    check("rst_held_sticky", 32'(if0.region_clicked), 0);
    ml = 1'b0; step(3);
    check("rst_held_m1", 32'(if1.click_pulse), 0);

    // Wide arithmetic: 2047+2047 must not wrap in 11 bits.
    at(4000, 100); step(2);
    check("ovf_hover", 32'(if0.hover), 32'b1000);
    ml = 1'b1; step(3);
    check("ovf_pulse", 32'(if0.click_pulse), 1);
    check("ovf_id", 32'(if0.click_id), 3);
    ml = 1'b0; step(3);
    check("ovf_m1_id", 32'(if1.click_id), 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
